// File: rtl/uop_pkg.sv
// Shared definitions for the uop sequencer: uop word fields, widths and state encoding.
package uop_pkg;

  localparam int unsigned UOP_END_BIT = 23;
  localparam int unsigned UOP_OP_HI   = 31;
  localparam int unsigned UOP_OP_LO   = 24;
  localparam int unsigned UOP_PC_W    = 12;
  localparam int unsigned REG_IDX_W   = 7;

  // Sequencer state encoding, kept numerically identical to the legacy design.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEQ  = 1'b1;

  // Returns the END flag of a uop word.
  function automatic logic uopIsEnd(input logic [31:0] word);
    return word[UOP_END_BIT];
  endfunction

endpackage

// File: rtl/uop_sequencer.sv
// Uop sequencer: registers single-uop instructions through to execute and walks
// multi-uop programs out of the external uop ROM, holding decode meanwhile.
module uop_sequencer
  import uop_pkg::*;
#(
  parameter int unsigned MAX_UOPS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 idValid,
  input  logic                 idUseSeq,
  input  logic [UOP_PC_W-1:0]  idUopPc,
  input  logic [31:0]          idUopWord,
  input  logic [REG_IDX_W-1:0] idRegD,
  input  logic [REG_IDX_W-1:0] idRegS,
  input  logic [REG_IDX_W-1:0] idRegT,
  input  logic [31:0]          idImm,
  input  logic [1:0]           idStepPc,
  input  logic                 exHold,
  input  logic                 exFlush,
  input  logic [31:0]          romData,
  output logic [UOP_PC_W-1:0]  romAddr,
  output logic                 sqHoldDec,
  output logic                 sqValid,
  output logic [31:0]          sqUopWord,
  output logic [UOP_PC_W-1:0]  sqUopPc,
  output logic [REG_IDX_W-1:0] sqRegD,
  output logic [REG_IDX_W-1:0] sqRegS,
  output logic [REG_IDX_W-1:0] sqRegT,
  output logic [31:0]          sqImm,
  output logic [1:0]           sqStepPc,
  output logic                 sqBusy,
  output logic                 sqFault
);

  localparam int unsigned CNT_W = $clog2(MAX_UOPS + 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       stepStored;
  logic             overrun;
  logic             seqLast;
  logic [31:0]      seqWord;

  // Decide whether the uop now on romData ends the sequence, forcing END on overrun.
  always_comb begin
    overrun = (CNT_W'(cnt + 1'b1) == CNT_W'(MAX_UOPS));
    seqLast = uopIsEnd(romData) | overrun;
    seqWord = romData;
    if (overrun) seqWord[UOP_END_BIT] = 1'b1;
  end

  assign sqBusy    = (state == ST_SEQ);
  assign sqHoldDec = (state == ST_SEQ) | exHold;

  // Sequencer state and output registers; reset > flush > hold > normal.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      stepStored <= '0;
      romAddr    <= '0;
      sqValid    <= 1'b0;
      sqUopWord  <= '0;
      sqUopPc    <= '0;
      sqRegD     <= '0;
      sqRegS     <= '0;
      sqRegT     <= '0;
      sqImm      <= '0;
      sqStepPc   <= '0;
      sqFault    <= 1'b0;
    end else if (exFlush) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sqValid <= 1'b0;
      sqFault <= 1'b0;
    end else if (!exHold) begin
      sqFault <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (idValid) begin
            sqValid    <= 1'b1;
            sqUopWord  <= idUopWord;
            sqRegD     <= idRegD;
            sqRegS     <= idRegS;
            sqRegT     <= idRegT;
            sqImm      <= idImm;
            stepStored <= idStepPc;
            if (idUseSeq && !uopIsEnd(idUopWord)) begin
              sqUopPc  <= idUopPc;
              sqStepPc <= '0;
              cnt      <= CNT_W'(1);
              romAddr  <= idUopPc + 1'b1;
              state    <= ST_SEQ;
            end else begin
              sqUopPc  <= '0;
              sqStepPc <= idStepPc;
            end
          end else begin
            sqValid <= 1'b0;
          end
        end
        ST_SEQ: begin
          sqValid <= 1'b1;
          sqUopPc <= romAddr;
          if (seqLast) begin
            sqUopWord <= seqWord;
            sqStepPc  <= stepStored;
            sqFault   <= overrun & ~uopIsEnd(romData);
            cnt       <= '0;
            state     <= ST_IDLE;
          end else begin
            sqUopWord <= romData;
            sqStepPc  <= '0;
            cnt       <= CNT_W'(cnt + 1'b1);
            romAddr   <= romAddr + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uop_sequencer.sv
// Directed bench for uop_sequencer with a scoreboard of expected per-cycle outputs.
module tb_uop_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        idValid;
  logic        idUseSeq;
  logic [11:0] idUopPc;
  logic [31:0] idUopWord;
  logic [6:0]  idRegD, idRegS, idRegT;
  logic [31:0] idImm;
  logic [1:0]  idStepPc;
  logic        exHold;
  logic        exFlush;
  logic [31:0] romData;
  logic [11:0] romAddr;
  logic        sqHoldDec, sqValid, sqBusy, sqFault;
  logic [31:0] sqUopWord, sqImm;
  logic [11:0] sqUopPc;
  logic [6:0]  sqRegD, sqRegS, sqRegT;
  logic [1:0]  sqStepPc;

  logic [31:0] rom [4096];

  typedef struct {
    logic        valid;
    logic [31:0] word;
    logic [11:0] pc;
    logic [1:0]  step;
    logic        hold;
    logic        busy;
    logic        fault;
    logic [11:0] addr;
    logic [6:0]  regD;
    logic [6:0]  regS;
    logic [6:0]  regT;
    logic [31:0] imm;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   nAsserts = 0;
  int   nFail    = 0;

  always #5 clk = ~clk;

  // ROM address register lives in the sequencer, so the array reads combinationally.
  assign romData = rom[romAddr];

  uop_sequencer #(.MAX_UOPS(16)) dut (
    .clk(clk), .reset(reset), .idValid(idValid), .idUseSeq(idUseSeq),
    .idUopPc(idUopPc), .idUopWord(idUopWord), .idRegD(idRegD), .idRegS(idRegS),
    .idRegT(idRegT), .idImm(idImm), .idStepPc(idStepPc), .exHold(exHold),
    .exFlush(exFlush), .romData(romData), .romAddr(romAddr), .sqHoldDec(sqHoldDec),
    .sqValid(sqValid), .sqUopWord(sqUopWord), .sqUopPc(sqUopPc), .sqRegD(sqRegD),
    .sqRegS(sqRegS), .sqRegT(sqRegT), .sqImm(sqImm), .sqStepPc(sqStepPc),
    .sqBusy(sqBusy), .sqFault(sqFault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1ns after the edge, and compare against the oldest expectation.
  task automatic tick(input string step);
    exp_t x;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({step, ".sbEmpty"}, 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      chk({step, ".valid"}, 32'(sqValid),   32'(x.valid));
      chk({step, ".word"},  sqUopWord,      x.word);
      chk({step, ".pc"},    32'(sqUopPc),   32'(x.pc));
      chk({step, ".step"},  32'(sqStepPc),  32'(x.step));
      chk({step, ".hold"},  32'(sqHoldDec), 32'(x.hold));
      chk({step, ".busy"},  32'(sqBusy),    32'(x.busy));
      chk({step, ".fault"}, 32'(sqFault),   32'(x.fault));
      chk({step, ".addr"},  32'(romAddr),   32'(x.addr));
      chk({step, ".regD"},  32'(sqRegD),    32'(x.regD));
      chk({step, ".regS"},  32'(sqRegS),    32'(x.regS));
      chk({step, ".regT"},  32'(sqRegT),    32'(x.regT));
      chk({step, ".imm"},   sqImm,          x.imm);
    end
  endtask

  task automatic drive(input logic v, input logic useSeq, input logic [11:0] pc,
                       input logic [31:0] word, input logic [1:0] step,
                       input logic [6:0] rd, input logic [31:0] imm);
    idValid   = v;
    idUseSeq  = useSeq;
    idUopPc   = pc;
    idUopWord = word;
    idStepPc  = step;
    idRegD    = rd;
    idRegS    = rd + 7'd1;
    idRegT    = rd + 7'd2;
    idImm     = imm;
  endtask

  task automatic expRegs(input logic [6:0] rd, input logic [31:0] imm);
    e.regD = rd;
    e.regS = rd + 7'd1;
    e.regT = rd + 7'd2;
    e.imm  = imm;
  endtask

  initial begin
    for (int unsigned i = 0; i < 4096; i++) rom[i] = 32'h0;
    rom[12'h041] = 32'h1100_0000;
    rom[12'h042] = 32'h1280_0000;
    rom[12'h081] = 32'h2100_0000;
    rom[12'h082] = 32'h2200_0000;
    rom[12'h083] = 32'h2380_0000;
    rom[12'h0C1] = 32'h3100_0000;
    for (int unsigned i = 1; i < 16; i++) rom[12'h100 + i] = {8'(8'h50 + i), 24'h0};
    rom[12'h110] = 32'h5F00_0000;
    rom[12'h000] = 32'h6080_0000;
    rom[12'h201] = 32'h7000_0000;

    // Reset: every output zero.
    reset = 1'b1; exHold = 1'b0; exFlush = 1'b0;
    drive(1'b0, 1'b0, 12'h0, 32'h0, 2'd0, 7'd0, 32'h0);
    e = '{valid:0, word:0, pc:0, step:0, hold:0, busy:0, fault:0, addr:0,
          regD:0, regS:0, regT:0, imm:0};
    sb.push_back(e); tick("reset");
    reset = 1'b0;

    // Pass-through single uop; idUopPc must be ignored.
    drive(1'b1, 1'b0, 12'h123, 32'h0A00_0000, 2'd1, 7'd3, 32'hDEAD_BEEF);
    e.valid = 1; e.word = 32'h0A00_0000; e.pc = 0; e.step = 1; expRegs(7'd3, 32'hDEAD_BEEF);
    sb.push_back(e); tick("pass");

    // Idle cycle: valid drops, rest holds.
    drive(1'b0, 1'b0, 12'h0, 32'h0, 2'd0, 7'd0, 32'h0);
    e.valid = 0;
    sb.push_back(e); tick("idle");

    // Three-uop sequence at 0x040.
    drive(1'b1, 1'b1, 12'h040, 32'h1000_0000, 2'd2, 7'd10, 32'h0000_1234);
    e.valid = 1; e.word = 32'h1000_0000; e.pc = 12'h040; e.step = 0;
    e.hold = 1; e.busy = 1; e.addr = 12'h041; expRegs(7'd10, 32'h0000_1234);
    sb.push_back(e); tick("seq3.u0");
    drive(1'b0, 1'b0, 12'h0, 32'h0, 2'd0, 7'd0, 32'h0);
    e.word = 32'h1100_0000; e.pc = 12'h041; e.addr = 12'h042;
    sb.push_back(e); tick("seq3.u1");
    e.word = 32'h1280_0000; e.pc = 12'h042; e.step = 2; e.hold = 0; e.busy = 0;
    sb.push_back(e); tick("seq3.u2");
    e.valid = 0;
    sb.push_back(e); tick("seq3.idle");

    // Hold for three cycles in the middle of a four-uop sequence.
    drive(1'b1, 1'b1, 12'h080, 32'h2000_0000, 2'd3, 7'd20, 32'hCAFE_0001);
    e.valid = 1; e.word = 32'h2000_0000; e.pc = 12'h080; e.step = 0;
    e.hold = 1; e.busy = 1; e.addr = 12'h081; expRegs(7'd20, 32'hCAFE_0001);
    sb.push_back(e); tick("hold.u0");
    drive(1'b0, 1'b0, 12'h0, 32'h0, 2'd0, 7'd0, 32'h0);
    e.word = 32'h2100_0000; e.pc = 12'h081; e.addr = 12'h082;
    sb.push_back(e); tick("hold.u1");
    exHold = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      sb.push_back(e); tick("hold.frozen");
    end
    exHold = 1'b0;
    e.word = 32'h2200_0000; e.pc = 12'h082; e.addr = 12'h083;
    sb.push_back(e); tick("hold.u2");
    e.word = 32'h2380_0000; e.pc = 12'h083; e.step = 3; e.hold = 0; e.busy = 0;
    sb.push_back(e); tick("hold.u3");
    e.valid = 0;
    sb.push_back(e); tick("hold.idle");

    // Flush while sequencing with a new instruction presented: it is dropped.
    drive(1'b1, 1'b1, 12'h0C0, 32'h3000_0000, 2'd1, 7'd30, 32'h0000_00C0);
    e.valid = 1; e.word = 32'h3000_0000; e.pc = 12'h0C0; e.step = 0;
    e.hold = 1; e.busy = 1; e.addr = 12'h0C1; expRegs(7'd30, 32'h0000_00C0);
    sb.push_back(e); tick("flush.u0");
    drive(1'b1, 1'b0, 12'h0, 32'h4000_0000, 2'd2, 7'd40, 32'h4444_4444);
    exFlush = 1'b1;
    e.valid = 0; e.hold = 0; e.busy = 0;
    sb.push_back(e); tick("flush.cut");
    exFlush = 1'b0;
    drive(1'b0, 1'b0, 12'h0, 32'h0, 2'd0, 7'd0, 32'h0);
    sb.push_back(e); tick("flush.idle");

    // Overrun: sixteen uops without END; the last is forced to END and faults.
    drive(1'b1, 1'b1, 12'h100, 32'h5000_0000, 2'd2, 7'd50, 32'h0000_0100);
    e.valid = 1; e.word = 32'h5000_0000; e.pc = 12'h100; e.step = 0;
    e.hold = 1; e.busy = 1; e.addr = 12'h101; expRegs(7'd50, 32'h0000_0100);
    sb.push_back(e); tick("ovr.u0");
    drive(1'b0, 1'b0, 12'h0, 32'h0, 2'd0, 7'd0, 32'h0);
    for (int unsigned i = 1; i < 16; i++) begin
      e.word = {8'(8'h50 + i), 24'h0};
      e.pc   = 12'(12'h100 + i);
      if (i == 15) begin
        e.word = e.word | 32'h0080_0000;
        e.step = 2; e.hold = 0; e.busy = 0; e.fault = 1;
      end else begin
        e.addr = 12'(12'h101 + i);
      end
      sb.push_back(e); tick("ovr.un");
    end
    e.valid = 0; e.fault = 0;
    sb.push_back(e); tick("ovr.after");

    // Address wrap from 0xFFF to 0x000.
    drive(1'b1, 1'b1, 12'hFFF, 32'h6100_0000, 2'd1, 7'd60, 32'h0000_0FFF);
    e.valid = 1; e.word = 32'h6100_0000; e.pc = 12'hFFF; e.step = 0;
    e.hold = 1; e.busy = 1; e.addr = 12'h000; expRegs(7'd60, 32'h0000_0FFF);
    sb.push_back(e); tick("wrap.u0");
    drive(1'b0, 1'b0, 12'h0, 32'h0, 2'd0, 7'd0, 32'h0);
    e.word = 32'h6080_0000; e.pc = 12'h000; e.step = 1; e.hold = 0; e.busy = 0;
    sb.push_back(e); tick("wrap.u1");

    // Reset in the middle of a sequence clears everything.
    drive(1'b1, 1'b1, 12'h200, 32'h7100_0000, 2'd3, 7'd70, 32'h7777_7777);
    e.valid = 1; e.word = 32'h7100_0000; e.pc = 12'h200; e.step = 0;
    e.hold = 1; e.busy = 1; e.addr = 12'h201; expRegs(7'd70, 32'h7777_7777);
    sb.push_back(e); tick("rst.u0");
    drive(1'b0, 1'b0, 12'h0, 32'h0, 2'd0, 7'd0, 32'h0);
    e.word = 32'h7000_0000; e.pc = 12'h201; e.addr = 12'h202;
    sb.push_back(e); tick("rst.u1");
    reset = 1'b1;
    e = '{valid:0, word:0, pc:0, step:0, hold:0, busy:0, fault:0, addr:0,
          regD:0, regS:0, regT:0, imm:0};
    sb.push_back(e); tick("rst.cleared");
    reset = 1'b0;

    chk("sb.drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
